// File: rtl/move_validation_ctrl_if.sv
// Signal bundle between the move-check controller, the game FSM, the board RAM
// and the six piece validators.
interface move_validation_ctrl_if;
  logic        req;
  logic        player;
  logic [2:0]  piece_x;
  logic [2:0]  piece_y;
  logic [2:0]  move_x;
  logic [2:0]  move_y;
  logic [2:0]  board_x;
  logic [2:0]  board_y;
  logic [3:0]  board_piece;
  logic [5:0]  val_start;
  logic [5:0]  val_complete;
  logic [5:0]  val_valid;
  logic [17:0] val_x;
  logic [17:0] val_y;
  logic [3:0]  val_piece;
  logic        busy;
  logic        done;
  logic        move_valid;
  logic [2:0]  err_code;

  modport master (
    output req, player, piece_x, piece_y, move_x, move_y,
    output board_piece, val_complete, val_valid, val_x, val_y,
    input  board_x, board_y, val_start, val_piece, busy, done, move_valid, err_code
  );

  modport slave (
    input  req, player, piece_x, piece_y, move_x, move_y,
    input  board_piece, val_complete, val_valid, val_x, val_y,
    output board_x, board_y, val_start, val_piece, busy, done, move_valid, err_code
  );
endinterface

// File: rtl/move_validation_ctrl.sv
// Sequences one chess-move check: reads source/destination squares, rejects
// illegal combinations, then hands the board read port to the matching piece validator.
module move_validation_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                   clk,
  input logic                   reset,
  move_validation_ctrl_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ_SRC = 3'd1,
    S_CHK_SRC  = 3'd2,
    S_READ_DST = 3'd3,
    S_CHK_DST  = 3'd4,
    S_DISPATCH = 3'd5,
    S_WAIT     = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t          state_r, next_s;
  logic [2:0]      src_x_r, src_y_r, dst_x_r, dst_y_r;
  logic            player_r;
  logic [2:0]      type_r;
  logic [2:0]      addr_x_r, addr_y_r;
  logic [CW-1:0]   cnt_r;
  logic            busy_r, done_r, move_valid_r;
  logic [2:0]      err_r;
  logic [5:0]      val_start_r;

  logic [5:0]      onehot_s;
  logic            sel_complete_s, sel_valid_s;
  logic [2:0]      sel_x_s, sel_y_s;
  logic [2:0]      err_s;
  logic            verdict_s;

  // Decode the latched piece type into the selected validator's handshake and address
  always_comb begin
    onehot_s       = 6'd0;
    sel_complete_s = 1'b0;
    sel_valid_s    = 1'b0;
    sel_x_s        = 3'd0;
    sel_y_s        = 3'd0;
    for (int i = 0; i < 6; i++) begin
      onehot_s[i]    = (type_r == 3'(i + 1));
      sel_complete_s = sel_complete_s | (onehot_s[i] & bus.val_complete[i]);
      sel_valid_s    = sel_valid_s | (onehot_s[i] & bus.val_valid[i]);
      sel_x_s        = sel_x_s | ({3{onehot_s[i]}} & bus.val_x[3*i +: 3]);
      sel_y_s        = sel_y_s | ({3{onehot_s[i]}} & bus.val_y[3*i +: 3]);
    end
  end

  // Next-state logic with the error code and verdict that go with entering DONE
  always_comb begin
    next_s    = state_r;
    err_s     = 3'd0;
    verdict_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.req) begin
          next_s = S_READ_SRC;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_READ_SRC: next_s = S_CHK_SRC;
      S_CHK_SRC: begin
        // Null move outranks every square-content check
        if ((src_x_r == dst_x_r) && (src_y_r == dst_y_r)) begin
          err_s = 3'd3;
        end else if (bus.board_piece[2:0] == 3'd0) begin
          err_s = 3'd1;
        end else if (bus.board_piece[2:0] == 3'd7) begin
          err_s = 3'd6;
        end else if (bus.board_piece[3] != player_r) begin
          err_s = 3'd2;
        end else begin
          err_s = 3'd0;
        end
        if (err_s != 3'd0) begin
          next_s = S_DONE;
        end else begin
          next_s = S_READ_DST;
        end
      end
      S_READ_DST: next_s = S_CHK_DST;
      S_CHK_DST: begin
        if ((bus.board_piece[2:0] != 3'd0) && (bus.board_piece[3] == player_r)) begin
          err_s  = 3'd4;
          next_s = S_DONE;
        end else begin
          next_s = S_DISPATCH;
        end
      end
      S_DISPATCH: next_s = S_WAIT;
      S_WAIT: begin
        if (sel_complete_s) begin
          verdict_s = sel_valid_s;
          next_s    = S_DONE;
        end else if (cnt_r == CW'(TIMEOUT_CYCLES - 1)) begin
          err_s  = 3'd5;
          next_s = S_DONE;
        end else begin
          next_s = S_WAIT;
        end
      end
      S_DONE:  next_s = S_IDLE;
      default: next_s = S_IDLE;
    endcase
  end

  // State, latched request context and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      src_x_r      <= 3'd0;
      src_y_r      <= 3'd0;
      dst_x_r      <= 3'd0;
      dst_y_r      <= 3'd0;
      player_r     <= 1'b0;
      type_r       <= 3'd0;
      addr_x_r     <= 3'd0;
      addr_y_r     <= 3'd0;
      cnt_r        <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      move_valid_r <= 1'b0;
      err_r        <= 3'd0;
      val_start_r  <= 6'd0;
    end else begin
      state_r     <= next_s;
      busy_r      <= (next_s != S_IDLE);
      done_r      <= (next_s == S_DONE);
      val_start_r <= (next_s == S_DISPATCH) ? onehot_s : 6'd0;
      if (state_r == S_WAIT) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= '0;
      end
      if ((state_r == S_IDLE) && bus.req) begin
        src_x_r      <= bus.piece_x;
        src_y_r      <= bus.piece_y;
        dst_x_r      <= bus.move_x;
        dst_y_r      <= bus.move_y;
        player_r     <= bus.player;
        addr_x_r     <= bus.piece_x;
        addr_y_r     <= bus.piece_y;
        move_valid_r <= 1'b0;
        err_r        <= 3'd0;
      end else if ((state_r == S_CHK_SRC) && (next_s == S_READ_DST)) begin
        type_r   <= bus.board_piece[2:0];
        addr_x_r <= dst_x_r;
        addr_y_r <= dst_y_r;
      end else if (next_s == S_DONE) begin
        move_valid_r <= verdict_s;
        err_r        <= err_s;
      end
    end
  end

  // The selected validator owns the read port only while it is running
  assign bus.board_x    = (state_r == S_WAIT) ? sel_x_s : addr_x_r;
  assign bus.board_y    = (state_r == S_WAIT) ? sel_y_s : addr_y_r;
  assign bus.val_piece  = bus.board_piece;
  assign bus.val_start  = val_start_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.move_valid = move_valid_r;
  assign bus.err_code   = err_r;

endmodule

// File: tb/tb_move_validation_ctrl.sv
// Directed bench for move_validation_ctrl with a registered board RAM and simple validator models.
module tb_move_validation_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  move_validation_ctrl_if bus ();
  move_validation_ctrl #(.TIMEOUT_CYCLES(64)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [3:0] ram [0:63];
  logic [5:0] resp_en = 6'd0, resp_valid = 6'd0, noise_c = 6'd0, noise_v = 6'd0;
  logic [5:0] comp_r = 6'd0, vv_r = 6'd0;

  // Registered board RAM: one cycle from address to data
  always @(posedge clk) bus.board_piece <= ram[{bus.board_y, bus.board_x}];

  // Validators answer on the first WAIT cycle when enabled
  always @(posedge clk) begin
    comp_r <= bus.val_start & resp_en;
    vv_r   <= bus.val_start & resp_valid;
  end
  assign bus.val_complete = comp_r | noise_c;
  assign bus.val_valid    = vv_r | noise_v;
  assign bus.val_x = {3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd5};
  assign bus.val_y = {3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd6};

  task automatic clear_board();
    for (int i = 0; i < 64; i++) ram[i] = 4'h0;
  endtask

  task automatic do_check(input logic [2:0] px, input logic [2:0] py, input logic [2:0] mx,
                          input logic [2:0] my, input logic pl, input int max_cyc, input bit busy_req,
                          output int lat, output logic mv, output logic [2:0] err, output int vs_cyc,
                          output logic [5:0] vs5, output logic [2:0] ax6, output logic [2:0] ay6);
    lat = -1; mv = 1'bx; err = 3'bx; vs_cyc = 0; vs5 = 6'bx; ax6 = 3'bx; ay6 = 3'bx;
    @(negedge clk);
    bus.req = 1'b1; bus.piece_x = px; bus.piece_y = py;
    bus.move_x = mx; bus.move_y = my; bus.player = pl;
    @(posedge clk);
    #1 bus.req = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (bus.val_start != 6'd0) vs_cyc++;
      if (k == 5) vs5 = bus.val_start;
      if (k == 6) begin ax6 = bus.board_x; ay6 = bus.board_y; end
      bus.req = busy_req && (k == 10);
      if (bus.done) begin
        lat = k; mv = bus.move_valid; err = bus.err_code;
        break;
      end
    end
    bus.req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.move_valid, bus.err_code, bus.val_start, bus.board_x, bus.board_y} !== 18'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b mv=%b err=%0d vs=%b bx=%0d by=%0d required all 0",
               bus.busy, bus.done, bus.move_valid, bus.err_code, bus.val_start, bus.board_x, bus.board_y);
    end
    reset = 1'b0;
  endtask

  task automatic test_king_move();
    int lat, vs; logic mv; logic [2:0] err, ax, ay; logic [5:0] v5;
    clear_board();
    ram[{3'd0, 3'd4}] = 4'h1;
    resp_en = 6'b000001; resp_valid = 6'b000001;
    noise_c = 6'b000010; noise_v = 6'b000000;
    do_check(3'd4, 3'd0, 3'd4, 3'd1, 1'b0, 20, 1'b0, lat, mv, err, vs, v5, ax, ay);
    total++; if (lat !== 7) begin bad++; $display("FAIL king_latency got=%0d required=7", lat); end
    total++; if (mv !== 1'b1) begin bad++; $display("FAIL king_move_valid got=%b required=1", mv); end
    total++; if (err !== 3'd0) begin bad++; $display("FAIL king_err got=%0d required=0", err); end
    total++; if (v5 !== 6'b000001) begin bad++; $display("FAIL king_val_start got=%b required=000001", v5); end
    total++; if (vs !== 1) begin bad++; $display("FAIL king_start_width got=%0d required=1", vs); end
    total++; if ({ax, ay} !== {3'd5, 3'd6}) begin bad++; $display("FAIL king_wait_addr got=%0d,%0d required=5,6", ax, ay); end
    @(negedge clk);
    total++; if ({bus.busy, bus.move_valid} !== 2'b01) begin bad++; $display("FAIL king_after_done got busy=%b mv=%b required busy=0 mv=1", bus.busy, bus.move_valid); end
    noise_c = 6'd0;
  endtask

  task automatic test_src_errors();
    int lat, vs; logic mv; logic [2:0] err, ax, ay; logic [5:0] v5;
    clear_board();
    do_check(3'd2, 3'd2, 3'd2, 3'd3, 1'b0, 20, 1'b0, lat, mv, err, vs, v5, ax, ay);
    total++; if ({lat, mv, err} !== {32'd3, 1'b0, 3'd1}) begin bad++; $display("FAIL src_empty got lat=%0d mv=%b err=%0d required lat=3 mv=0 err=1", lat, mv, err); end
    ram[{3'd2, 3'd2}] = 4'b1001;
    do_check(3'd2, 3'd2, 3'd2, 3'd3, 1'b0, 20, 1'b0, lat, mv, err, vs, v5, ax, ay);
    total++; if ({lat, mv, err} !== {32'd3, 1'b0, 3'd2}) begin bad++; $display("FAIL src_wrong_colour got lat=%0d mv=%b err=%0d required lat=3 mv=0 err=2", lat, mv, err); end
    ram[{3'd2, 3'd2}] = 4'h7;
    do_check(3'd2, 3'd2, 3'd2, 3'd3, 1'b0, 20, 1'b0, lat, mv, err, vs, v5, ax, ay);
    total++; if ({lat, mv, err} !== {32'd3, 1'b0, 3'd6}) begin bad++; $display("FAIL src_bad_type got lat=%0d mv=%b err=%0d required lat=3 mv=0 err=6", lat, mv, err); end
    ram[{3'd2, 3'd2}] = 4'h0;
    do_check(3'd2, 3'd2, 3'd2, 3'd2, 1'b0, 20, 1'b0, lat, mv, err, vs, v5, ax, ay);
    total++; if ({lat, mv, err} !== {32'd3, 1'b0, 3'd3}) begin bad++; $display("FAIL null_move got lat=%0d mv=%b err=%0d required lat=3 mv=0 err=3", lat, mv, err); end
  endtask

  task automatic test_dst_own_piece();
    int lat, vs; logic mv; logic [2:0] err, ax, ay; logic [5:0] v5;
    clear_board();
    ram[{3'd0, 3'd0}] = 4'h5;
    ram[{3'd1, 3'd0}] = 4'h6;
    resp_en = 6'b111111; resp_valid = 6'b111111;
    do_check(3'd0, 3'd0, 3'd0, 3'd1, 1'b0, 20, 1'b0, lat, mv, err, vs, v5, ax, ay);
    total++; if ({lat, mv, err} !== {32'd5, 1'b0, 3'd4}) begin bad++; $display("FAIL dst_own got lat=%0d mv=%b err=%0d required lat=5 mv=0 err=4", lat, mv, err); end
    total++; if (vs !== 0) begin bad++; $display("FAIL dst_own_no_start got=%0d required=0", vs); end
  endtask

  task automatic test_timeout();
    int lat, vs, late_busy; logic mv; logic [2:0] err, ax, ay; logic [5:0] v5;
    clear_board();
    ram[{3'd0, 3'd3}] = 4'h2;
    resp_en = 6'd0; resp_valid = 6'd0;
    do_check(3'd3, 3'd0, 3'd3, 3'd3, 1'b0, 100, 1'b1, lat, mv, err, vs, v5, ax, ay);
    total++; if ({lat, mv, err} !== {32'd70, 1'b0, 3'd5}) begin bad++; $display("FAIL timeout got lat=%0d mv=%b err=%0d required lat=70 mv=0 err=5", lat, mv, err); end
    total++; if ({ax, ay} !== {3'd2, 3'd3}) begin bad++; $display("FAIL queen_wait_addr got=%0d,%0d required=2,3", ax, ay); end
    late_busy = 0;
    repeat (4) begin @(negedge clk); if (bus.busy) late_busy++; end
    total++; if (late_busy !== 0) begin bad++; $display("FAIL busy_req_ignored got busy_cycles=%0d required=0", late_busy); end
  endtask

  task automatic test_reset_mid_wait();
    int lat, vs, dn; logic mv; logic [2:0] err, ax, ay; logic [5:0] v5;
    do_check(3'd3, 3'd0, 3'd3, 3'd3, 1'b0, 12, 1'b0, lat, mv, err, vs, v5, ax, ay);
    total++; if (lat !== -1) begin bad++; $display("FAIL pre_reset_no_done got lat=%0d required=-1", lat); end
    reset = 1'b1;
    @(negedge clk);
    total++; if ({bus.busy, bus.done, bus.val_start} !== 8'd0) begin bad++; $display("FAIL reset_mid_wait got busy=%b done=%b vs=%b required 0", bus.busy, bus.done, bus.val_start); end
    reset = 1'b0;
    dn = 0;
    repeat (8) begin @(negedge clk); if (bus.done || bus.busy) dn++; end
    total++; if (dn !== 0) begin bad++; $display("FAIL reset_no_done got=%0d required=0", dn); end
    clear_board();
    ram[{3'd7, 3'd1}] = 4'hC;
    ram[{3'd5, 3'd2}] = 4'h6;
    resp_en = 6'b111111; resp_valid = 6'b000000;
    do_check(3'd1, 3'd7, 3'd2, 3'd5, 1'b1, 20, 1'b0, lat, mv, err, vs, v5, ax, ay);
    total++; if ({lat, mv, err} !== {32'd7, 1'b0, 3'd0}) begin bad++; $display("FAIL knight_after_reset got lat=%0d mv=%b err=%0d required lat=7 mv=0 err=0", lat, mv, err); end
    total++; if ({vs, v5} !== {32'd1, 6'b001000}) begin bad++; $display("FAIL knight_start got cycles=%0d vs=%b required 1,001000", vs, v5); end
  endtask

  initial begin
    bus.req = 1'b0; bus.player = 1'b0;
    bus.piece_x = 3'd0; bus.piece_y = 3'd0; bus.move_x = 3'd0; bus.move_y = 3'd0;
    clear_board();
    test_reset();
    test_king_move();
    test_src_errors();
    test_dst_own_piece();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
